// File: rtl/seq_fsm_param.sv
// seq_fsm_param: a Moore sequencer driven by a table that can be reprogrammed at runtime.
//
// Each table entry holds four fields:
//   out   - value driven on Y while the sequencer is in that state
//   next0 - successor state when Control=0 at the transition edge
//   next1 - successor state when Control=1 at the transition edge
//   dwell - number of extra enabled cycles to stay in the state
// The legacy fixed 4-state sequencer is one way to program this table.
//
// Ports:
//   Clock, Reset   rising-edge clock; asynchronous active-high reset
//   Enable         1 lets the sequencer run; 0 freezes State and the dwell counter
//   SyncClear      synchronous return to state 0; overrides Enable and transitions
//   Control        selects next1 (1) or next0 (0) at a transition edge
//   CfgWe, CfgAddr, CfgOut, CfgNext0, CfgNext1, CfgDwell
//                  port used to write one whole table entry
//   Y              out field of entry[State] (combinational)
//   State          current state index
//   Advance        one-cycle pulse after every transition
//   Wrap           one-cycle pulse after a transition into state 0
//   CfgErr         one-cycle pulse after a rejected table write
module seq_fsm_param #(
  parameter int STATE_W    = 3,
  parameter int NUM_STATES = 8,
  parameter int OUT_W      = 8,
  parameter int DWELL_W    = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               SyncClear,
  input  logic               Control,
  input  logic               CfgWe,
  input  logic [STATE_W-1:0] CfgAddr,
  input  logic [OUT_W-1:0]   CfgOut,
  input  logic [STATE_W-1:0] CfgNext0,
  input  logic [STATE_W-1:0] CfgNext1,
  input  logic [DWELL_W-1:0] CfgDwell,
  output logic [OUT_W-1:0]   Y,
  output logic [STATE_W-1:0] State,
  output logic               Advance,
  output logic               Wrap,
  output logic               CfgErr
);

  // The table is sized to the full index space, so any State value is a legal index.
  // Entries at NUM_STATES and above are never written and never reached.
  // They keep their reset constants.
  localparam int TAB_N = 2 ** STATE_W;
  localparam logic [STATE_W:0] NUM_S = (STATE_W + 1)'(NUM_STATES);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_DWELL,
    ACT_STEP,
    ACT_CLEAR
  } act_t;

  logic [OUT_W-1:0]   tab_out   [TAB_N];
  logic [STATE_W-1:0] tab_next0 [TAB_N];
  logic [STATE_W-1:0] tab_next1 [TAB_N];
  logic [DWELL_W-1:0] tab_dwell [TAB_N];

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_d;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] succ;
  logic               adv_d;
  logic               wrap_d;
  logic               cfg_ok;
  act_t               act;

  // A write is accepted only when every index field names an implemented state.
  // This check is what keeps State inside 0..NUM_STATES-1.
  assign cfg_ok = ({1'b0, CfgAddr}  < NUM_S) &&
                  ({1'b0, CfgNext0} < NUM_S) &&
                  ({1'b0, CfgNext1} < NUM_S);

  assign Y = tab_out[State];

  // Table storage. Transition and dwell-load decisions read these registers directly.
  // On an edge that also writes the table, they therefore see the pre-write contents.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < TAB_N; i++) begin
        tab_out[i]   <= OUT_W'(i + 1);
        tab_next0[i] <= STATE_W'((i + 1) % NUM_STATES);
        tab_next1[i] <= STATE_W'((i + 1) % NUM_STATES);
        tab_dwell[i] <= '0;
      end
    end else if (CfgWe && cfg_ok) begin
      tab_out[CfgAddr]   <= CfgOut;
      tab_next0[CfgAddr] <= CfgNext0;
      tab_next1[CfgAddr] <= CfgNext1;
      tab_dwell[CfgAddr] <= CfgDwell;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      State   <= '0;
      cnt     <= '0;
      Advance <= 1'b0;
      Wrap    <= 1'b0;
      CfgErr  <= 1'b0;
    end else begin
      State   <= state_d;
      cnt     <= cnt_d;
      Advance <= adv_d;
      Wrap    <= wrap_d;
      CfgErr  <= CfgWe && !cfg_ok;
    end
  end

  // Choose one action per edge, in priority order: clear, then dwell countdown or step.
  always_comb begin
    act     = ACT_HOLD;
    succ    = Control ? tab_next1[State] : tab_next0[State];
    state_d = State;
    cnt_d   = cnt;
    adv_d   = 1'b0;
    wrap_d  = 1'b0;

    if (SyncClear) begin
      act = ACT_CLEAR;
    end else if (Enable) begin
      act = (cnt == '0) ? ACT_STEP : ACT_DWELL;
    end

    unique case (act)
      ACT_CLEAR: begin
        state_d = '0;
        cnt_d   = tab_dwell[0];
      end
      ACT_DWELL: begin
        cnt_d = cnt - DWELL_W'(1);
      end
      ACT_STEP: begin
        // Self-loops reload the dwell counter too, so a state with dwell=d
        // always lasts d+1 enabled cycles.
        state_d = succ;
        cnt_d   = tab_dwell[succ];
        adv_d   = 1'b1;
        wrap_d  = (succ == '0);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_seq_fsm_param.sv
module tb_seq_fsm_param;

  localparam int SW = 3;
  localparam int NS = 4;
  localparam int OW = 8;
  localparam int DW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Enable;
  logic          SyncClear;
  logic          Control;
  logic          CfgWe;
  logic [SW-1:0] CfgAddr;
  logic [OW-1:0] CfgOut;
  logic [SW-1:0] CfgNext0;
  logic [SW-1:0] CfgNext1;
  logic [DW-1:0] CfgDwell;
  logic [OW-1:0] Y;
  logic [SW-1:0] State;
  logic          Advance;
  logic          Wrap;
  logic          CfgErr;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference: the table as plain integers.
  // The model also tracks how many extra cycles are still owed in the current state.
  int m_out [NS];
  int m_n0  [NS];
  int m_n1  [NS];
  int m_dw  [NS];
  int m_state;
  int m_left;
  int m_adv;
  int m_wrap;
  int m_err;

  seq_fsm_param #(.STATE_W(SW), .NUM_STATES(NS), .OUT_W(OW), .DWELL_W(DW)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .SyncClear(SyncClear),
    .Control(Control), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgOut(CfgOut),
    .CfgNext0(CfgNext0), .CfgNext1(CfgNext1), .CfgDwell(CfgDwell),
    .Y(Y), .State(State), .Advance(Advance), .Wrap(Wrap), .CfgErr(CfgErr)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_out[i] = (i + 1) % 256;
      m_n0[i]  = (i + 1) % NS;
      m_n1[i]  = (i + 1) % NS;
      m_dw[i]  = 0;
    end
    m_state = 0; m_left = 0; m_adv = 0; m_wrap = 0; m_err = 0;
  endtask

  // One clock edge, worked out from the sequencing rules.
  // Both the transition and the write are decided against the old table.
  task automatic model_edge();
    int nst;
    int nleft;
    int a;
    int n0;
    int n1;
    nst = m_state; nleft = m_left; m_adv = 0; m_wrap = 0;
    if (SyncClear) begin
      nst = 0; nleft = m_dw[0];
    end else if (Enable) begin
      if (m_left > 0) nleft = m_left - 1;
      else begin
        nst = Control ? m_n1[m_state] : m_n0[m_state];
        nleft = m_dw[nst];
        m_adv = 1;
        m_wrap = (nst == 0) ? 1 : 0;
      end
    end
    a = int'(CfgAddr); n0 = int'(CfgNext0); n1 = int'(CfgNext1);
    m_err = 0;
    if (CfgWe) begin
      if (a < NS && n0 < NS && n1 < NS) begin
        m_out[a] = int'(CfgOut); m_n0[a] = n0; m_n1[a] = n1; m_dw[a] = int'(CfgDwell);
      end else m_err = 1;
    end
    m_state = nst; m_left = nleft;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".State"},   32'(State),   32'(m_state));
    chk({tag, ".Y"},       32'(Y),       32'(m_out[m_state]));
    chk({tag, ".Advance"}, 32'(Advance), 32'(m_adv));
    chk({tag, ".Wrap"},    32'(Wrap),    32'(m_wrap));
    chk({tag, ".CfgErr"},  32'(CfgErr),  32'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge Clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic wr(input int a, input int o, input int n0, input int n1, input int d, input string tag);
    CfgWe = 1'b1; CfgAddr = SW'(a); CfgOut = OW'(o);
    CfgNext0 = SW'(n0); CfgNext1 = SW'(n1); CfgDwell = DW'(d);
    step(tag);
    CfgWe = 1'b0;
  endtask

  task automatic clear(input string tag);
    SyncClear = 1'b1;
    step(tag);
    SyncClear = 1'b0;
  endtask

  task automatic wait_state(input int s, input int maxc, input string tag);
    int n;
    n = 0;
    while (int'(State) != s && n < maxc) begin
      step(tag);
      n++;
    end
    chk({tag, ".reach"}, 32'(State), 32'(s));
  endtask

  initial begin
    int legacy1 [4];
    int legacy0 [3];
    legacy1 = '{2, 3, 4, 1};
    legacy0 = '{2, 4, 1};
    Reset = 1'b1; Enable = 1'b0; SyncClear = 1'b0; Control = 1'b0;
    CfgWe = 1'b0; CfgAddr = '0; CfgOut = '0; CfgNext0 = '0; CfgNext1 = '0; CfgDwell = '0;
    model_reset();
    #7;
    check_all("reset");
    chk("reset.Y_is_1", 32'(Y), 32'd1);
    Reset = 1'b0;

    // Default table: walk 0,1,2,3,0,...
    Enable = 1'b1; Control = 1'b0;
    for (int i = 0; i < 9; i++) step("walk");

    // Legacy program.
    Enable = 1'b0;
    wr(0, 1, 1, 1, 0, "prog0");
    wr(1, 2, 3, 2, 0, "prog1");
    wr(2, 3, 3, 3, 0, "prog2");
    wr(3, 4, 0, 0, 0, "prog3");
    clear("legacy.clr");
    chk("legacy.start", 32'(Y), 32'd1);
    Enable = 1'b1; Control = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("legacy1");
      chk("legacy1.Yseq", 32'(Y), 32'(legacy1[i]));
    end
    clear("legacy.clr2");
    Control = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("legacy0");
      chk("legacy0.Yseq", 32'(Y), 32'(legacy0[i]));
    end

    // Dwell: entry0 held 4 enabled cycles; 2 disabled cycles stretch that by 2.
    Enable = 1'b0;
    wr(0, 1, 1, 1, 3, "dwell.wr");
    clear("dwell.clr");
    Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("dwell.hold");
      chk("dwell.hold_s0", 32'(State), 32'd0);
    end
    step("dwell.leave");
    chk("dwell.leave_s1", 32'(State), 32'd1);
    clear("dwell.clr2");
    step("dwell.en1");
    Enable = 1'b0;
    step("dwell.off1");
    step("dwell.off2");
    Enable = 1'b1;
    step("dwell.en2");
    step("dwell.en3");
    chk("dwell.stretched_s0", 32'(State), 32'd0);
    step("dwell.en4");
    chk("dwell.stretched_s1", 32'(State), 32'd1);

    // Rejected writes leave the table untouched.
    Enable = 1'b0;
    wr(5, 8'hAA, 0, 0, 0, "bad.addr");
    chk("bad.addr_err", 32'(CfgErr), 32'd1);
    step("bad.idle");
    chk("bad.err_drop", 32'(CfgErr), 32'd0);
    wr(1, 8'h55, 0, 7, 0, "bad.next1");
    chk("bad.next1_err", 32'(CfgErr), 32'd1);

    // SyncClear wins over a transition that is due in state 2.
    clear("sc.clr");
    Enable = 1'b1; Control = 1'b1;
    wait_state(2, 20, "sc.go");
    SyncClear = 1'b1;
    step("sc.hit");
    SyncClear = 1'b0;
    chk("sc.State", 32'(State), 32'd0);
    chk("sc.Advance", 32'(Advance), 32'd0);
    chk("sc.Wrap", 32'(Wrap), 32'd0);
    chk("sc.Y", 32'(Y), 32'd1);

    // A write on the same edge as a transition: the old next0 applies now, the new one next pass.
    Control = 1'b1;
    wait_state(3, 20, "col.go");
    Control = 1'b0;
    wr(3, 4, 2, 2, 0, "col.wr");
    chk("col.old_next0", 32'(State), 32'd0);
    wait_state(3, 20, "col.again");
    step("col.new");
    chk("col.new_next0", 32'(State), 32'd2);

    // Asynchronous reset in the middle of a dwell.
    Enable = 1'b0;
    wr(2, 3, 3, 3, 5, "ar.wr");
    Enable = 1'b1;
    step("ar.s3");
    wait_state(2, 20, "ar.go");
    step("ar.mid1");
    step("ar.mid2");
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("ar.async");
    chk("ar.Y_is_1", 32'(Y), 32'd1);
    #1;
    Reset = 1'b0;

    // Random traffic, with occasional invalid writes and same-edge collisions.
    for (int i = 0; i < 400; i++) begin
      Enable    = ($urandom_range(0, 3) != 0);
      Control   = 1'($urandom_range(0, 1));
      SyncClear = ($urandom_range(0, 15) == 0);
      CfgWe     = ($urandom_range(0, 5) == 0);
      CfgAddr   = SW'($urandom_range(0, 5));
      CfgOut    = OW'($urandom_range(0, 255));
      CfgNext0  = SW'($urandom_range(0, 4));
      CfgNext1  = SW'($urandom_range(0, 4));
      CfgDwell  = DW'($urandom_range(0, 3));
      step("rand");
    end
    CfgWe = 1'b0; SyncClear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_fsm_param.md
Name: seq_fsm_param

Overview:
- Parametrised, table-driven Moore sequencer.
- Successor to the team's fixed 4-state Control-branching FSM.
- Each state has a runtime-programmable output value, two successor states selected by Control, and a dwell time; Enable and SyncClear gate sequencing.
- Used as a generic control-sequence generator; the legacy 4-state 1/2/3/4 behaviour is one table programming.

Parameters:
STATE_W, 3, state index width
NUM_STATES, 8, number of implemented states (2..2^STATE_W)
OUT_W, 8, width of per-state output Y
DWELL_W, 4, width of per-state dwell count

Ports:
Clock  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  sequencing enable; 0 freezes State and dwell counter
SyncClear  in  1  synchronous return to state 0
Control  in  1  branch select at transition
CfgWe  in  1  table write strobe
CfgAddr  in  STATE_W  table entry index
CfgOut  in  OUT_W  output value for entry
CfgNext0  in  STATE_W  successor when Control=0
CfgNext1  in  STATE_W  successor when Control=1
CfgDwell  in  DWELL_W  extra cycles held in state
Y  out  OUT_W  out field of entry[State]
State  out  STATE_W  current state
Advance  out  1  one-cycle pulse: State changed/reloaded on previous edge
Wrap  out  1  one-cycle pulse with Advance when new State==0
CfgErr  out  1  one-cycle pulse: rejected table write

Behaviour:
- Reset is asynchronous and active-high on Clock domain registers.
- Reset values:
  - State=0, dwell counter=0, Advance=0, Wrap=0, CfgErr=0.
  - Table entry i: out=i+1 (truncated to OUT_W), next0=next1=(i+1) mod NUM_STATES, dwell=0.
  - Hence Y=1 after reset.
- Y is combinational from State and table registers; no added latency. A write to entry[State] changes Y in the cycle after the write edge.
- Dwell counter:
  - Loaded with entry[new State].dwell on every transition, including self-loops, and on SyncClear.
  - On each edge with Enable=1 and counter!=0, the counter decrements; State holds.
- Transition:
  - Occurs on an edge with Enable=1, SyncClear=0 and counter==0.
  - State <= Control ? entry[State].next1 : entry[State].next0.
  - Control is sampled at that edge only.
  - A state with dwell=d is occupied d+1 enabled cycles.
- Pulses:
  - Advance=1 for the single cycle after each transition.
  - Wrap=1 additionally when the new State==0.
  - Both are registered, and both are 0 whenever no transition occurred.
- SyncClear:
  - Priority over Enable and over transitions.
  - State<=0, counter<=entry[0].dwell, Advance<=0, Wrap<=0.
  - Table contents unaffected.
- Enable=0: State, counter and Y frozen; Advance/Wrap 0.
- Table write, on an edge with CfgWe=1:
  - If CfgAddr<NUM_STATES and CfgNext0<NUM_STATES and CfgNext1<NUM_STATES, the whole entry is written.
  - Otherwise nothing is written and CfgErr pulses high for the next cycle.
  - Writes are accepted regardless of Enable or SyncClear.
- Write/transition collision:
  - A transition or dwell load on the same edge as a write uses the pre-write table contents.
  - This covers writes to the current entry and to the successor entry.
- State is never outside 0..NUM_STATES-1 (guaranteed by write checking and reset defaults).
- Reset asserted mid-operation restores the reset table and state immediately, independent of Clock.

Test Plan:
1. NUM_STATES=4, defaults, Enable=1, Control=0:
   - Response: State 0,1,2,3,0…; Y 1,2,3,4,1…
   - Advance high every cycle after the first edge; Wrap high once per 4 cycles.
2. Legacy program: entry0 next0=next1=1; entry1 next0=3, next1=2; entry2 next0=next1=3; entry3 next0=next1=0; Control=1 in state 1:
   - Control=1 → Y 1,2,3,4.
   - Rerun with Control=0 in state 1 → Y 1,2,4.
3. Write entry0 dwell=3, then Enable=1:
   - State 0 held 4 enabled cycles, then 1.
   - Drop Enable for 2 cycles mid-dwell → occupancy extended by exactly 2.
4. Invalid writes:
   - CfgAddr=5 with NUM_STATES=4 → CfgErr 1 cycle, table unchanged.
   - Entry with CfgNext1=7 → rejected, CfgErr.
5. SyncClear asserted in state 2 together with Enable and a due transition:
   - Next cycle State=0, Y=entry0.out, Advance=0, Wrap=0.
6. Same-edge write of entry[State].next0=2 while transitioning with Control=0:
   - Transition follows the old next0.
   - The following pass through that state uses 2.
   - Async Reset mid-dwell → State=0, Y=1 without a clock edge.
